// File: rtl/spi_slave.sv
// SPI mode 0/2 slave (CPHA=0) with 2-flop synchronized pins and back-to-back words per frame.
// Defining SPI_SLAVE_FRAME_ERR_EN adds the frame_err output for aborted partial words.
module spi_slave #(
   parameter int CPOL       = 0,
   parameter int DATA_WIDTH = 8,
   parameter int MSB_FIRST  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_pin,
   input  logic                  ncs_pin,
   input  logic                  mosi_pin,
   output logic                  miso_pin,
   output logic                  oe_pin,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_load,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
   output logic                  frame_err,
`endif
   output logic                  spi_busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

   logic             sck_p0, sck_p1, sck_p2;
   logic             ncs_p0, ncs_p1, ncs_p2;
   logic             mosi_p0, mosi_p1;
   logic             prime_p0, prime_p1, armed;
   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [DATA_WIDTH-1:0] rx_sr, tx_sr;
   logic             sck_rise, sck_fall, lead, trail, ncs_fall, ncs_rise, last_bit;

   // Wire-order bit idx of a natural-order word.
   function automatic logic wire_bit(input logic [DATA_WIDTH-1:0] w, input logic [CNT_W-1:0] idx);
      logic [CNT_W-1:0] i;
      i = (MSB_FIRST != 0) ? (LAST - idx) : idx;
      return w[i];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] sr, input logic b);
      if (MSB_FIRST != 0) return {sr[DATA_WIDTH-2:0], b};
      else                return {b, sr[DATA_WIDTH-1:1]};
   endfunction

   // Stage p0/p1: synchronizers; p2: previous value for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_p0   <= 1'b0;
         sck_p1   <= 1'b0;
         sck_p2   <= 1'b0;
         ncs_p0   <= 1'b1;
         ncs_p1   <= 1'b1;
         ncs_p2   <= 1'b1;
         mosi_p0  <= 1'b0;
         mosi_p1  <= 1'b0;
         prime_p0 <= 1'b0;
         prime_p1 <= 1'b0;
         armed    <= 1'b0;
      end else begin
         sck_p0   <= clk_pin;
         sck_p1   <= sck_p0;
         sck_p2   <= sck_p1;
         ncs_p0   <= ncs_pin;
         ncs_p1   <= ncs_p0;
         ncs_p2   <= ncs_p1;
         mosi_p0  <= mosi_pin;
         mosi_p1  <= mosi_p0;
         prime_p0 <= 1'b1;
         prime_p1 <= prime_p0;
         // A frame may only start once ncs has really been seen high after reset.
         if (prime_p1 && ncs_p1) armed <= 1'b1;
      end
   end

   assign sck_rise = sck_p1 & ~sck_p2;
   assign sck_fall = ~sck_p1 & sck_p2;
   assign lead     = (CPOL != 0) ? sck_fall : sck_rise;
   assign trail    = (CPOL != 0) ? sck_rise : sck_fall;
   assign ncs_fall = ~ncs_p1 & ncs_p2 & armed;
   assign ncs_rise = ncs_p1 & ~ncs_p2;
   assign last_bit = lead && (cnt == LAST);
   assign spi_busy = (state == SHIFT);

   // Stage p3: frame FSM, shift registers and output pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rx_sr    <= '0;
         tx_sr    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_load  <= 1'b0;
         miso_pin <= 1'b0;
         oe_pin   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         tx_load  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (ncs_fall) begin
                  state    <= SHIFT;
                  tx_sr    <= tx_data;
                  tx_load  <= 1'b1;
                  cnt      <= '0;
                  oe_pin   <= 1'b1;
                  miso_pin <= wire_bit(tx_data, '0);
               end
            end
            default: begin
               if (lead) begin
                  rx_sr <= shift_in(rx_sr, mosi_p1);
                  if (cnt == LAST) begin
                     rx_data  <= shift_in(rx_sr, mosi_p1);
                     rx_valid <= 1'b1;
                     cnt      <= '0;
                     // No reload when the frame ends on the final bit: nothing would be sent.
                     if (!ncs_rise) begin
                        tx_sr   <= tx_data;
                        tx_load <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (trail) begin
                  miso_pin <= wire_bit(tx_sr, cnt);
               end
               if (ncs_rise) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  oe_pin   <= 1'b0;
                  miso_pin <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                  frame_err <= (cnt != '0) && !last_bit;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboarded bench: mode-0/MSB-first and mode-2/LSB-first slaves share one SPI bus.
module tb_spi_slave;

   localparam int H = 60;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       sclk_n;
   logic       ncs = 1'b1;
   logic       mosi = 1'b0;
   logic [7:0] tx_data;
   logic [7:0] tx_tab [0:63];
   int         tx_idx = 0;

   logic       miso0, oe0, tl0_p, rv0_p, busy0;
   logic       miso1, oe1, tl1_p, rv1_p, busy1;
   logic [7:0] rx0, rx1;

   int checks = 0;
   int errors = 0;
   int tl0 = 0, tl1 = 0, rv0 = 0, rv1 = 0, oe_hits = 0;
   bit watch_idle = 1'b0;
   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];

   assign sclk_n  = ~sclk;
   assign tx_data = tx_tab[tx_idx[5:0]];

   always #5 clk = ~clk;

`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic fe0, fe1;
   int   fec0 = 0, fec1 = 0;
   always @(negedge clk) begin
      if (fe0) fec0++;
      if (fe1) fec1++;
   end
`endif

   spi_slave #(.CPOL(0), .DATA_WIDTH(8), .MSB_FIRST(1)) dut0 (
      .clk(clk), .rst(rst), .clk_pin(sclk), .ncs_pin(ncs), .mosi_pin(mosi),
      .miso_pin(miso0), .oe_pin(oe0), .tx_data(tx_data), .tx_load(tl0_p),
      .rx_data(rx0), .rx_valid(rv0_p),
`ifdef SPI_SLAVE_FRAME_ERR_EN
      .frame_err(fe0),
`endif
      .spi_busy(busy0));

   spi_slave #(.CPOL(1), .DATA_WIDTH(8), .MSB_FIRST(0)) dut1 (
      .clk(clk), .rst(rst), .clk_pin(sclk_n), .ncs_pin(ncs), .mosi_pin(mosi),
      .miso_pin(miso1), .oe_pin(oe1), .tx_data(tx_data), .tx_load(tl1_p),
      .rx_data(rx1), .rx_valid(rv1_p),
`ifdef SPI_SLAVE_FRAME_ERR_EN
      .frame_err(fe1),
`endif
      .spi_busy(busy1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] w);
      return {<<{w}};
   endfunction

   // Monitor: pop expected words on every rx_valid, count tx_load pulses.
   always @(negedge clk) begin
      if (rv0_p) begin
         rv0++;
         if (exp0.size() == 0) check("rx0_unexpected", 32'(rx0), 32'hFFFF_FFFF);
         else check("rx0_word", 32'(rx0), 32'(exp0.pop_front()));
      end
      if (rv1_p) begin
         rv1++;
         if (exp1.size() == 0) check("rx1_unexpected", 32'(rx1), 32'hFFFF_FFFF);
         else check("rx1_word", 32'(rx1), 32'(exp1.pop_front()));
      end
      if (tl0_p) begin
         tl0++;
         tx_idx++;
      end
      if (tl1_p) tl1++;
      if (watch_idle && (oe0 || oe1)) oe_hits++;
   end

   task automatic frame_start();
      ncs = 1'b0;
      #(H);
   endtask

   task automatic frame_end();
      #(H);
      ncs = 1'b1;
      #(2 * H);
   endtask

   // Master: shifts wire bits first-to-last from w[7], reads both MISO lines the same way.
   task automatic send_bits(input logic [7:0] w, input int nbits, input bit coinc,
                            output logic [7:0] r0, output logic [7:0] r1);
      logic [7:0] wv;
      wv = w;
      r0 = '0;
      r1 = '0;
      for (int k = 0; k < nbits; k++) begin
         mosi = wv[7];
         wv   = wv << 1;
         #(H);
         r0   = {r0[6:0], miso0};
         r1   = {r1[6:0], miso1};
         sclk = 1'b1;
         if (coinc && k == nbits - 1) ncs = 1'b1;
         #(H);
         sclk = 1'b0;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_dut0"}, 32'({miso0, oe0, rv0_p, tl0_p, busy0, rx0}), 32'd0);
      check({tag, "_dut1"}, 32'({miso1, oe1, rv1_p, tl1_p, busy1, rx1}), 32'd0);
   endtask

   initial begin
      logic [7:0] r0, r1;
      int tl_s, rv_s;
      for (int i = 0; i < 64; i++) tx_tab[i] = 8'h00;

      repeat (3) @(negedge clk);
      check_reset_outs("reset");
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // Single word, frame closed on the last leading edge.
      tx_tab[tx_idx[5:0]] = 8'h3C;
      exp0.push_back(8'hA5); exp1.push_back(rev8(8'hA5));
      tl_s = tl0; rv_s = rv0;
      frame_start();
      check("busy_oe_in_frame", 32'({busy0, oe0, busy1, oe1}), 32'hF);
      send_bits(8'hA5, 8, 1'b1, r0, r1);
      #(2 * H);
      check("t1_read0", 32'(r0), 32'h3C);
      check("t1_read1", 32'(r1), 32'(rev8(8'h3C)));
      check("t1_tx_load", 32'(tl0 - tl_s), 32'd1);
      check("t1_rx_valid", 32'(rv0 - rv_s), 32'd1);
      check("t1_idle_outs", 32'({miso0, oe0, busy0, miso1, oe1, busy1}), 32'd0);

      // LSB-first slave sees 0x01 when the first wire bit is 1.
      tx_tab[tx_idx[5:0]] = 8'h96;
      exp0.push_back(8'h80); exp1.push_back(8'h01);
      tl_s = tl0;
      frame_start();
      send_bits(8'h80, 8, 1'b0, r0, r1);
      frame_end();
      check("t2_read0", 32'(r0), 32'h96);
      check("t2_read1", 32'(r1), 32'h69);
      check("t2_tx_load", 32'(tl0 - tl_s), 32'd2);
      check("t2_tx_load1", 32'(tl1 - tl_s), 32'd2);

      // Three words under one chip select, tx_data stepped on each load.
      tx_tab[(tx_idx + 0) % 64] = 8'hAA;
      tx_tab[(tx_idx + 1) % 64] = 8'hBB;
      tx_tab[(tx_idx + 2) % 64] = 8'hCC;
      tx_tab[(tx_idx + 3) % 64] = 8'h00;
      exp0.push_back(8'h11); exp0.push_back(8'h22); exp0.push_back(8'h33);
      exp1.push_back(8'h88); exp1.push_back(8'h44); exp1.push_back(8'hCC);
      tl_s = tl0; rv_s = rv0;
      frame_start();
      send_bits(8'h11, 8, 1'b0, r0, r1);
      check("t3_read_w0", 32'(r0), 32'hAA);
      send_bits(8'h22, 8, 1'b0, r0, r1);
      check("t3_read_w1", 32'(r0), 32'hBB);
      send_bits(8'h33, 8, 1'b0, r0, r1);
      check("t3_read_w2", 32'(r0), 32'hCC);
      check("t3_read_w2_lsb", 32'(r1), 32'h33);
      frame_end();
      check("t3_rx_valid", 32'(rv0 - rv_s), 32'd3);
      check("t3_tx_load", 32'(tl0 - tl_s), 32'd4);

      // Aborted partial word, then a clean word.
      rv_s = rv0;
      frame_start();
      send_bits(8'hFF, 5, 1'b0, r0, r1);
      frame_end();
      check("t4_no_rx_valid", 32'(rv0 - rv_s + rv1 - rv_s), 32'(rv1 - rv_s));
      check("t4_rx0_held", 32'(rx0), 32'h33);
      check("t4_rx1_held", 32'(rx1), 32'hCC);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("t4_frame_err0", 32'(fec0), 32'd1);
      check("t4_frame_err1", 32'(fec1), 32'd1);
`endif
      exp0.push_back(8'h5A); exp1.push_back(rev8(8'h5A));
      frame_start();
      send_bits(8'h5A, 8, 1'b0, r0, r1);
      frame_end();
      check("t4_rx0_after", 32'(rx0), 32'h5A);

      // Reset in mid-frame, ncs kept low across reset release.
      frame_start();
      send_bits(8'hC3, 4, 1'b0, r0, r1);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outs("mid_reset");
      rst = 1'b0;
      rv_s = rv0;
      repeat (6) @(negedge clk);
      send_bits(8'hFF, 8, 1'b0, r0, r1);
      check("t5_idle_after_rst", 32'({busy0, busy1, oe0, oe1}), 32'd0);
      check("t5_no_rx_valid", 32'(rv0 - rv_s), 32'd0);
      frame_end();
      exp0.push_back(8'hC3); exp1.push_back(rev8(8'hC3));
      frame_start();
      send_bits(8'hC3, 8, 1'b0, r0, r1);
      frame_end();
      check("t5_rx0", 32'(rx0), 32'hC3);
      check("t5_rx1", 32'(rx1), 32'hC3);

      // Free-running clock with chip select high.
      tl_s = tl0; rv_s = rv0;
      watch_idle = 1'b1;
      for (int k = 0; k < 200; k++) begin
         #50;
         sclk = ~sclk;
      end
      #(2 * H);
      watch_idle = 1'b0;
      check("t6_oe_low", 32'(oe_hits), 32'd0);
      check("t6_no_tx_load", 32'(tl0 - tl_s), 32'd0);
      check("t6_no_rx_valid", 32'(rv0 - rv_s), 32'd0);
      check("t6_busy_low", 32'({busy0, busy1}), 32'd0);

`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("final_frame_err", 32'(fec0 + fec1), 32'd2);
`endif
      check("final_exp0_drained", 32'(exp0.size()), 32'd0);
      check("final_exp1_drained", 32'(exp1.size()), 32'd0);
      check("final_rv_match", 32'(rv1), 32'(rv0));
      check("final_rv_total", 32'(rv0), 32'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
